// File: rtl/exec_stage_md_if.sv
// exec_stage_md_if
// Bundles the execute stage's handshake and data bus.
//   slave  : the execute stage itself (takes decode inputs, drives results)
//   master : the environment around it (decode + memory stage side)
// Inputs from decode:  flush, in_valid, rd1_d, rd2_d, fwd_a_en/fwd_a,
//                      fwd_b_en/fwd_b, imm_d, shamt_d, rt_d, rd_d,
//                      alu_op_d, alu_src_d, ctrl_d
// Handshake:           in_ready (stage->decode), out_valid/out_ready
// Results to memory:   alu_out, write_data, write_reg, ctrl_e, busy
interface exec_stage_md_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int SW   = $clog2(XLEN)
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic            fwd_a_en;
  logic [XLEN-1:0] fwd_a;
  logic            fwd_b_en;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] imm_d;
  logic [SW-1:0]   shamt_d;
  logic [RW-1:0]   rt_d;
  logic [RW-1:0]   rd_d;
  logic [3:0]      alu_op_d;
  logic [1:0]      alu_src_d;
  logic [3:0]      ctrl_d;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] write_data;
  logic [RW-1:0]   write_reg;
  logic [2:0]      ctrl_e;
  logic            busy;

  modport slave (
    input  flush, in_valid, rd1_d, rd2_d, fwd_a_en, fwd_a, fwd_b_en, fwd_b,
           imm_d, shamt_d, rt_d, rd_d, alu_op_d, alu_src_d, ctrl_d, out_ready,
    output in_ready, out_valid, alu_out, write_data, write_reg, ctrl_e, busy
  );

  modport master (
    output flush, in_valid, rd1_d, rd2_d, fwd_a_en, fwd_a, fwd_b_en, fwd_b,
           imm_d, shamt_d, rt_d, rd_d, alu_op_d, alu_src_d, ctrl_d, out_ready,
    input  in_ready, out_valid, alu_out, write_data, write_reg, ctrl_e, busy
  );
endinterface

// File: rtl/exec_stage_md.sv
// exec_stage_md
// Pipeline execute stage holding one op. Single-cycle ALU ops are computed
// at capture and presented the next cycle; MULU/DIVU/REMU iterate for XLEN
// cycles (shift-add / restoring shift-subtract) before being presented.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : exec_stage_md_if.slave (decode inputs, valid/ready handshakes,
//          registered results to the memory stage)
module exec_stage_md #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int SW   = $clog2(XLEN)
) (
  input logic           clk,
  input logic           rst,
  exec_stage_md_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ITER, FULL} state_t;

  state_t          state;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] wdata_q;
  logic [RW-1:0]   wreg_q;
  logic [2:0]      ctrl_q;
  logic [3:0]      op_q;
  logic [SW-1:0]   cnt_q;
  // Iteration registers: acc = product / partial remainder,
  // x = multiplier (shifted right) / dividend turning into quotient,
  // y = multiplicand (shifted left) / divisor.
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] x_q;
  logic [XLEN-1:0] y_q;

  logic            pop;
  logic            capture;
  logic            last;
  logic            is_md;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_sum;
  logic [XLEN:0]   div_tmp;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] iter_res;

  assign bus.out_valid  = (state == FULL);
  assign bus.busy       = (state == ITER);
  assign pop            = bus.out_valid && bus.out_ready;
  assign bus.in_ready   = ((state != FULL) || pop) && (state != ITER);
  assign capture        = bus.in_valid && bus.in_ready && !bus.flush;
  assign last           = (cnt_q == SW'(XLEN - 1));
  assign is_md          = (bus.alu_op_d >= 4'd12) && (bus.alu_op_d != 4'd15);

  assign bus.alu_out    = alu_q;
  assign bus.write_data = wdata_q;
  assign bus.write_reg  = wreg_q;
  // Control bits are only meaningful alongside a valid result.
  assign bus.ctrl_e     = bus.out_valid ? ctrl_q : 3'b000;

  // Operand selection: forwarding first, then the alu_src muxes.
  assign src_a = bus.fwd_a_en ? bus.fwd_a : bus.rd1_d;
  assign src_b = bus.fwd_b_en ? bus.fwd_b : bus.rd2_d;
  assign op_a  = bus.alu_src_d[0] ? {{(XLEN-SW){1'b0}}, bus.shamt_d} : src_a;
  assign op_b  = bus.alu_src_d[1] ? bus.imm_d : src_b;

  // Single-cycle ALU, evaluated on the operands being captured.
  always_comb begin
    alu_res = op_b;
    case (bus.alu_op_d)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a & op_b;
      4'd3:  alu_res = op_a | op_b;
      4'd4:  alu_res = op_a ^ op_b;
      4'd5:  alu_res = ~(op_a | op_b);
      4'd6:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd7:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd8:  alu_res = op_b << op_a[SW-1:0];
      4'd9:  alu_res = op_b >> op_a[SW-1:0];
      4'd10: alu_res = $signed(op_b) >>> op_a[SW-1:0];
      4'd11: alu_res = op_b << 16;
      default: alu_res = op_b;
    endcase
  end

  // One mul/div step. A zero divisor always "fits", which naturally
  // yields an all-ones quotient and shifts the dividend into the remainder.
  assign mul_sum  = acc_q + (x_q[0] ? y_q : '0);
  assign div_tmp  = {acc_q, x_q[XLEN-1]};
  assign div_diff = div_tmp - {1'b0, y_q};
  assign div_ge   = ~div_diff[XLEN];
  assign rem_nx   = div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
  assign quo_nx   = {x_q[XLEN-2:0], div_ge};
  assign iter_res = (op_q == 4'd12) ? mul_sum :
                    (op_q == 4'd13) ? quo_nx  : rem_nx;

  // Stage FSM and all result registers. Flush wins over everything, then
  // an in-progress iteration, then capture, then a plain pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      alu_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      ctrl_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
      cnt_q <= '0;
    end else if (state == ITER) begin
      if (op_q == 4'd12) begin
        acc_q <= mul_sum;
        x_q   <= x_q >> 1;
        y_q   <= y_q << 1;
      end else begin
        acc_q <= rem_nx;
        x_q   <= quo_nx;
      end
      cnt_q <= cnt_q + SW'(1);
      if (last) begin
        state <= FULL;
        alu_q <= iter_res;
        cnt_q <= '0;
      end
    end else if (capture) begin
      wdata_q <= src_b;
      wreg_q  <= bus.ctrl_d[0] ? bus.rd_d : bus.rt_d;
      ctrl_q  <= bus.ctrl_d[3:1];
      op_q    <= bus.alu_op_d;
      if (is_md) begin
        state <= ITER;
        cnt_q <= '0;
        acc_q <= '0;
        x_q   <= op_a;
        y_q   <= op_b;
      end else begin
        state <= FULL;
        alu_q <= alu_res;
      end
    end else if (pop) begin
      state <= EMPTY;
    end
  end

endmodule
